// File: rtl/or_arb_pkg.sv
// or_arb_pkg: shared FSM state type and parameter defaults for the OR-bus arbiter
// No ports; imported by or_bus_arbiter.
package or_arb_pkg;
    localparam int N_REQ_DEF    = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_HOLD_DEF = 15;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search for the first eligible request at or above ptr
// req_i   : request vector
// ptr_i   : search start index
// excl_i  : requesters barred from this search
// found_o : an eligible requester exists
// idx_o   : index of the chosen requester (0 when none)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  excl_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    logic [N-1:0]   cand;
    logic [2*N-1:0] rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    assign cand = req_i & ~excl_i;
    always_comb begin
        // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit is the winner.
        rot     = {cand, cand} >> ptr_i;
        found_o = |rot[N-1:0];
        off     = '0;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) off = IW'(j);
        sum   = {1'b0, ptr_i} + {1'b0, off};
        idx_o = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    end
endmodule

// File: rtl/or_bus_arbiter.sv
// or_bus_arbiter: round-robin arbiter with hold limit driving a wired-OR data bus
// clk, rst_n : clock, asynchronous active-low reset
// req        : per-requester level request
// din        : requester data, word i at [i*DATA_W +: DATA_W]
// gnt        : registered one-hot grant, zero when idle
// gnt_id     : granted index, zero when idle
// busy       : a grant is active
// y          : OR over requesters of data masked by grant
module or_bus_arbiter
    import or_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   din,
    output logic [N_REQ-1:0]          gnt,
    output logic [$clog2(N_REQ)-1:0]  gnt_id,
    output logic                      busy,
    output logic [DATA_W-1:0]         y
);
    localparam int IW = $clog2(N_REQ);
    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, excl;
    logic [IW-1:0]    gnt_id_q, gnt_id_d, ptr_q, ptr_d, pick_idx, next_ptr;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             pick_found, others, keep;
    // The current owner never wins its own re-arbitration, whether it released or is being rotated out.
    assign excl = (state_q == GRANT) ? gnt_q : '0;
    rr_pick #(.N(N_REQ)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .excl_i  (excl),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );
    assign next_ptr = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
    always_comb begin
        others     = |(req & ~gnt_q);
        // ">=" also covers a saturated counter when a contender finally shows up.
        keep       = (state_q == GRANT) && req[gnt_id_q] &&
                     !((hold_cnt_q >= 8'(MAX_HOLD - 1)) && others);
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = (hold_cnt_q < 8'(MAX_HOLD)) ? hold_cnt_q + 8'd1 : hold_cnt_q;
        if (!keep) begin
            state_d    = pick_found ? GRANT : IDLE;
            gnt_d      = pick_found ? (N_REQ'(1) << pick_idx) : '0;
            gnt_id_d   = pick_found ? pick_idx : '0;
            ptr_d      = pick_found ? next_ptr : ptr_q;
            hold_cnt_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end
    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == GRANT);
    always_comb begin
        y = '0;
        for (int i = 0; i < N_REQ; i++)
            y = y | (din[i*DATA_W +: DATA_W] & {DATA_W{gnt_q[i]}});
    end
endmodule

// File: tb/tb_or_bus_arbiter.sv
// tb_or_bus_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
module tb_or_bus_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] din = '0;
    logic [N-1:0]   gnt;
    logic [1:0]     gnt_id;
    logic           busy;
    logic [W-1:0]   y;
    int vectors = 0;
    int errors  = 0;
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;

    always #5 clk = ~clk;

    or_bus_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_HOLD(MH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .din    (din),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .y      (y)
    );

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    // Owner keeps the bus while requesting, until it has held MH cycles and someone else waits.
    task automatic model_step();
        bit others = 0;
        int nxt = -1;
        for (int j = 0; j < N; j++)
            if (j != m_owner && req[j]) others = 1;
        if (m_owner >= 0 && req[m_owner] && !(m_held >= MH && others)) begin
            m_held++;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (nxt < 0 && req[c] && c != m_owner) nxt = c;
            end
            m_owner = nxt;
            if (nxt >= 0) begin
                m_ptr  = (nxt + 1) % N;
                m_held = 1;
            end else begin
                m_held = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '1;
        din   = '1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (gnt !== 4'b0000 || y !== 8'h00 || busy !== 1'b0 || gnt_id !== 2'd0) begin
                errors++;
                $display("FAIL reset cyc%0d got gnt=%b id=%0d y=%h busy=%b exp 0000/0/00/0", c, gnt, gnt_id, y, busy);
            end
        end
        req   = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        din = {$urandom, $urandom};
        din[2*W +: W] = 8'hA5;
        req = 4'b0100;
        tick();
        vectors++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || y !== 8'hA5) begin
            errors++;
            $display("FAIL single_grant got gnt=%b id=%0d y=%h exp 0100/2/a5", gnt, gnt_id, y);
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (gnt !== 4'b0000 || y !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release got gnt=%b y=%h busy=%b exp 0000/00/0", gnt, y, busy);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                vectors++;
                if (gnt !== (4'b0001 << (g % 4)) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rr g%0d c%0d got gnt=%b busy=%b exp %b/1", g, c, gnt, busy, 4'b0001 << (g % 4));
                end
                req = (c == 2) ? (4'b1111 & ~(4'b0001 << (g % 4))) : 4'b1111;
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_hold_limit();
        apply_reset();
        req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            tick();
            vectors++;
            if (gnt !== 4'b0001) begin
                errors++;
                $display("FAIL hold cyc%0d got gnt=%b exp 0001", c, gnt);
            end
            req = 4'b0011;
        end
        tick();
        vectors++;
        if (gnt !== 4'b0010 || dut.hold_cnt_q !== 8'd0) begin
            errors++;
            $display("FAIL hold_rotate got gnt=%b hold=%0d exp 0010/0", gnt, dut.hold_cnt_q);
        end
        req = '0;
        tick();
    endtask

    task automatic test_no_contender();
        apply_reset();
        req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            tick();
            vectors++;
            if (gnt !== 4'b1000 || dut.hold_cnt_q !== 8'((c > MH) ? MH : c)) begin
                errors++;
                $display("FAIL solo cyc%0d got gnt=%b hold=%0d exp 1000/%0d", c, gnt, dut.hold_cnt_q, (c > MH) ? MH : c);
            end
        end
        vectors++;
        if (dut.hold_cnt_q !== 8'd4) begin
            errors++;
            $display("FAIL solo_sat got hold=%0d exp 4", dut.hold_cnt_q);
        end
        req = '0;
        tick();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        req = 4'b0100;
        tick();
        req = 4'b0110;
        tick();
        vectors++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_pre got gnt=%b exp 0100", gnt);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (gnt !== 4'b0000 || y !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got gnt=%b y=%h busy=%b exp 0000/00/0", gnt, y, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL midrst_post got gnt=%b id=%0d exp 0010/1", gnt, gnt_id);
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        logic [W-1:0] ey;
        int eh;
        for (int it = 0; it < 500; it++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            din = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            tick();
            eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
            ey = (m_owner < 0) ? '0 : din[m_owner*W +: W];
            eh = (m_owner < 0) ? 0 : ((m_held - 1 > MH) ? MH : m_held - 1);
            vectors++;
            if (gnt !== eg || gnt_id !== 2'((m_owner < 0) ? 0 : m_owner) || busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL rand_grant it%0d req=%b got gnt=%b id=%0d busy=%b exp gnt=%b owner=%0d", it, req, gnt, gnt_id, busy, eg, m_owner);
            end
            vectors++;
            if (y !== ey) begin
                errors++;
                $display("FAIL rand_bus it%0d got y=%h exp %h", it, y, ey);
            end
            vectors++;
            if (dut.hold_cnt_q !== 8'(eh)) begin
                errors++;
                $display("FAIL rand_hold it%0d got %0d exp %0d", it, dut.hold_cnt_q, eh);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold_limit();
        test_no_contender();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/or_bus_arbiter.md
OR_BUS_ARBITER -- requirements
Module: or_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter DATA_W, default 8: width of each requester data word and of the bus.
REQ-003 SHALL have parameter MAX_HOLD, default 15: grant cycles before forced rotation, legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, N_REQ bits: per-requester level request, held high while it wants the bus.
REQ-007 SHALL have port din, input, N_REQ*DATA_W bits: requester i data at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port gnt, output, N_REQ bits: registered one-hot grant, all zero when idle.
REQ-009 SHALL have port gnt_id, output, clog2(N_REQ) bits: index of the granted requester, 0 when idle.
REQ-010 SHALL have port busy, output, 1 bit: high while any grant is active.
REQ-011 SHALL have port y, output, DATA_W bits: shared wired-OR bus, equal to the OR over i of (din_i AND gnt[i] replicated).

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-013 SHALL transition IDLE->GRANT at the first rising edge where req != 0, granting the first set req bit searching upward from ptr with wrap-around.
REQ-014 SHALL hold ptr, the round-robin start index: on every new grant to index k, ptr <= (k+1) mod N_REQ.
REQ-015 SHALL keep the grant while req[gnt_id] stays high, unless the hold limit in REQ-017 applies.
REQ-016 SHALL, when req[gnt_id] is low at an edge, re-arbitrate on that same edge: grant the next requester from ptr if any other req is high (GRANT->GRANT), otherwise go to IDLE with gnt cleared; there are no dead cycles between grants.
REQ-017 SHALL count cycles of the current grant in hold_cnt (8 bits, saturating at MAX_HOLD); when hold_cnt == MAX_HOLD-1 and any other req bit is high, the grant SHALL rotate on that edge even if req[gnt_id] is still high.
REQ-018 SHALL keep the grant indefinitely with hold_cnt saturated when no other requester is pending, and rotate on the first edge where another req is high.
REQ-019 SHALL reset hold_cnt to 0 on every new grant, including a re-grant to a different index.
REQ-020 SHALL have a latency of one edge from req rising (arbiter idle) to gnt rising; y SHALL follow din combinationally through the registered gnt.
REQ-021 SHALL never assert more than one gnt bit; y SHALL be 0 whenever gnt == 0.
REQ-022 SHALL resolve a release by the granted requester and a new request in the same cycle per REQ-016, with the new requester eligible.
REQ-023 SHALL exclude the releasing requester from re-arbitration on that edge even if its req returns high in the next cycle.

Reset
REQ-024 SHALL, while rst_n is low, force gnt=0, gnt_id=0, busy=0, y=0, state=IDLE, ptr=0 and hold_cnt=0, asynchronously.
REQ-025 SHALL, after reset is asserted mid-grant and then released, restart arbitration from ptr=0 on the first edge with rst_n high.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, GRANT) and the N_REQ, DATA_W and MAX_HOLD defaults in shared package or_arb_pkg.
REQ-027 SHALL implement priority search as one combinational sub-module, rr_pick (inputs req, ptr and exclude mask; outputs found and idx), instantiated once.
REQ-028 SHALL build y as a masked OR reduction from the gate primitives already in the library, with no tri-states.

Verification
REQ-029 SHALL cover reset: rst_n=0 with req=4'b1111 and all din=8'hFF -> gnt=0, y=8'h00 and busy=0 throughout reset.
REQ-030 SHALL cover single requester: req=4'b0100 and din2=8'hA5 -> next edge gnt=4'b0100, gnt_id=2, y=8'hA5; req drops -> next edge gnt=0, y=8'h00.
REQ-031 SHALL cover round-robin: req=4'b1111, each requester holds 3 cycles then releases -> grant order 0,1,2,3,0 with no idle cycle between grants.
REQ-032 SHALL cover hold limit: MAX_HOLD=4, req0 held forever and req1 raised at cycle 1 -> gnt0 for exactly 4 cycles, then gnt=4'b0010.
REQ-033 SHALL cover the no-contender case: MAX_HOLD=4 with only req3 held for 20 cycles -> gnt=4'b1000 for all 20 cycles and hold_cnt saturates at 4.
REQ-034 SHALL cover mid-grant reset: rst_n pulsed low during gnt=4'b0100 with req=4'b0110 -> gnt=0 immediately; after release, gnt=4'b0010 because ptr=0.
